lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised Galois LFSR: configurable width, feedback polynomial and shifts-per-cycle.
- Adds a stored seed, a period counter and a wrap pulse so software and BIST logic can confirm the sequence length.
- Keeps the all-zero lock-up recovery. Used as a scrambler, PRBS source and BIST pattern generator.

Parameters:
- WIDTH, 26, state width in bits; legal range 3..64.
- POLY, 26'h0000183, feedback tap mask (x^26+x^8+x^7+x+1); bit 0 must be 1; the x^WIDTH term is implicit.
- STEPS, 1, number of LFSR shifts applied per advance; legal range 1..WIDTH.
- CNT_W, 32, width of the period counter and the period output.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance the state by STEPS shifts this cycle
- load  in  1  load din as new state and new seed
- din  in  WIDTH  seed value for load
- q  out  WIDTH  current LFSR state (registered)
- wrap  out  1  one-cycle pulse: state has returned to the seed
- period  out  CNT_W  advances per full cycle, from the last wrap
- lock_fix  out  1  one-cycle pulse: all-zero state was recovered

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All outputs are registered.
- Reset (rst_n=0 at a rising edge) sets: q=0, seed=1, cnt=0, period=0, wrap=0, lock_fix=0. Reset overrides load and en. Asserting reset mid-sequence discards all state in that cycle.
- Single shift function f(s) = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{s[WIDTH-1]}} & POLY). An advance applies f STEPS times combinationally, within one cycle.
- Priority when rst_n=1: load, then zero-recovery, then advance, then hold.
- load=1:
  - q and seed are set to din, or to 1 if din==0.
  - cnt=0. wrap=0. lock_fix=0.
  - en is ignored that cycle.
- en=1, load=0, q==0:
  - q=1 and seed=1.
  - cnt=0, so the next wrap is measured from state 1.
  - lock_fix=1 for one cycle. No wrap.
- en=1, load=0, q!=0: q=fSTEPS(q).
  - If fSTEPS(q)==seed: wrap=1 for one cycle, period=cnt+1 (saturating), cnt=0.
  - Otherwise cnt=cnt+1, saturating at 2^CNT_W-1. Once saturated, cnt holds until the next load, wrap, recovery or reset.
  - If cnt is saturated when a wrap occurs, period shows all-ones, meaning "at least this many".
- en=0, load=0: q, seed, cnt and period hold. wrap=0 and lock_fix=0.
- wrap and lock_fix are never asserted in the same cycle.
- period holds its value until the next wrap or reset. A load does not clear period.
- Latency: q updates on the edge that samples en/load, so a new state is visible on the next cycle. wrap/period update on that same edge.
- STEPS>1: the seed may be stepped over when gcd(STEPS, sequence length) != 1. In that case wrap asserts only after exactly reaching the seed, and period counts advances, not shifts.
- Gating: q changes only on load, recovery or en. The state never becomes 0 except through reset.

Test Plan:
- WIDTH=4, POLY=4'h3, STEPS=1: load din=4'h1, then en held high. Required q sequence: 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1. wrap pulses on the cycle q returns to 1; period=15.
- Same configuration, load din=0: q=1 and seed=1 next cycle. After 15 en cycles: wrap=1, period=15.
- After reset, q=0. Assert en for one cycle: lock_fix=1, q=1, cnt=0. After 15 more en cycles: wrap=1, period=15.
- Assert load and en together with din=4'h9: q=9 with no advance. Reset asserted mid-run while en=1 forces q=0, seed=1, period=0 on that edge.
- WIDTH=4, POLY=4'h3, STEPS=2, load 1, en high: q sequence 1,4,3,C,5,7,F,9,2,8,6,B,A,E,D,1 (1 reached again after 15 advances, since gcd(2,15)=1). Required: wrap on the 15th advance, period=15. Toggling en low for 3 cycles mid-run must not change period.
- CNT_W=3, WIDTH=4, POLY=4'h3: load 1 and advance 15 times. cnt saturates at 7; on wrap, period=7.
- Default 26-bit configuration: load 1, advance 26 times. q must equal POLY (26'h0000183) after the 26th advance.

Source files
------------

// File: rtl/lfsr_gen.sv
// Galois LFSR with a configurable polynomial and shifts per advance, a stored seed,
// a saturating period counter, a wrap pulse, and recovery from the all-zero state.
module lfsr_gen #(
  parameter int unsigned       WIDTH = 26,
  parameter logic [WIDTH-1:0]  POLY  = 26'h0000183,
  parameter int unsigned       STEPS = 1,
  parameter int unsigned       CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic [CNT_W-1:0] period,
  output logic             lock_fix
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int unsigned i = 0; i < STEPS; i++)
      t = {t[WIDTH-2:0], 1'b0} ^ ({WIDTH{t[WIDTH-1]}} & POLY);
    return t;
  endfunction

  always_comb begin
    q_next  = advance(q);
    cnt_sat = &cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      seed     <= ONE;
      cnt      <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      lock_fix <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      lock_fix <= 1'b0;
      if (load) begin
        q    <= (din == '0) ? ONE : din;
        seed <= (din == '0) ? ONE : din;
        cnt  <= '0;
      end else if (en) begin
        if (q == '0) begin
          q        <= ONE;
          seed     <= ONE;
          cnt      <= '0;
          lock_fix <= 1'b1;
        end else begin
          q <= q_next;
          if (q_next == seed) begin
            // A saturated count reports all-ones, read as "at least this many".
            wrap   <= 1'b1;
            period <= cnt_sat ? cnt : cnt + CNT_W'(1);
            cnt    <= '0;
          end else if (!cnt_sat) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit instances (STEPS=1, STEPS=2, 3-bit counter)
// share stimulus; a default 26-bit instance checks the full-width polynomial.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, load;
  logic [3:0]  din;
  logic [25:0] din26;

  logic [3:0]  qa, qb, qc;
  logic        wa, wb, wc, la, lb, lc;
  logic [31:0] pa, pb;
  logic [2:0]  pc;
  logic [25:0] q26;
  logic        w26, l26;
  logic [31:0] p26;

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .STEPS(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
    .q(qa), .wrap(wa), .period(pa), .lock_fix(la));

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .STEPS(2), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
    .q(qb), .wrap(wb), .period(pb), .lock_fix(lb));

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .STEPS(1), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
    .q(qc), .wrap(wc), .period(pc), .lock_fix(lc));

  lfsr_gen dut_26 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din26),
    .q(q26), .wrap(w26), .period(p26), .lock_fix(l26));

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq1 [16];
  logic [3:0] seq2 [16];

  initial begin
    seq1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
             4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    seq2 = '{4'h1, 4'h4, 4'h3, 4'hC, 4'h5, 4'h7, 4'hF, 4'h9,
             4'h2, 4'h8, 4'h6, 4'hB, 4'hA, 4'hE, 4'hD, 4'h1};

    rst_n = 1'b0; en = 1'b0; load = 1'b0; din = '0; din26 = '0;
    tick; tick;
    check("rst_q",      64'(qa),  64'h0);
    check("rst_wrap",   64'(wa),  64'h0);
    check("rst_lock",   64'(la),  64'h0);
    check("rst_period", 64'(pa),  64'h0);
    check("rst_q26",    64'(q26), 64'h0);

    // Zero-state recovery, then one full period from state 1.
    rst_n = 1'b1; en = 1'b1;
    tick;
    check("rec_lock",  64'(la), 64'h1);
    check("rec_q",     64'(qa), 64'h1);
    check("rec_wrap",  64'(wa), 64'h0);
    check("rec_qb",    64'(qb), 64'h1);
    en = 1'b0;
    tick;
    check("rec_lock_clr", 64'(la), 64'h0);
    check("rec_hold_q",   64'(qa), 64'h1);
    en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick;
      check($sformatf("s2_q%0d", i), 64'(qb), 64'(seq2[i]));
      check($sformatf("rec_wrap%0d", i), 64'(wa), 64'(i == 15));
    end
    check("rec_period",   64'(pa), 64'd15);
    check("s2_wrap",      64'(wb), 64'h1);
    check("s2_period",    64'(pb), 64'd15);
    check("sat_wrap",     64'(wc), 64'h1);
    check("sat_period",   64'(pc), 64'd7);
    en = 1'b0;
    tick;
    check("wrap_clr", 64'(wa), 64'h0);

    // Load seed 1 and walk the full STEPS=1 sequence with an en-low gap.
    load = 1'b1; en = 1'b1; din = 4'h1;
    tick;
    load = 1'b0;
    check("ld1_q",    64'(qa), 64'h1);
    check("ld1_wrap", 64'(wa), 64'h0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 6) begin
        en = 1'b0;
        repeat (3) tick;
        check("gap_q",      64'(qa), 64'(seq1[5]));
        check("gap_period", 64'(pb), 64'd15);
        check("gap_wrap",   64'(wb), 64'h0);
        en = 1'b1;
      end
      tick;
      check($sformatf("s1_q%0d", i), 64'(qa), 64'(seq1[i]));
      check($sformatf("s1_wrap%0d", i), 64'(wa), 64'(i == 15));
    end
    check("s1_period", 64'(pa), 64'd15);

    // Loading zero substitutes seed 1.
    load = 1'b1; en = 1'b0; din = 4'h0;
    tick;
    load = 1'b0;
    check("ld0_q",    64'(qa), 64'h1);
    check("ld0_lock", 64'(la), 64'h0);
    en = 1'b1;
    repeat (14) tick;
    check("ld0_nowrap", 64'(wa), 64'h0);
    tick;
    check("ld0_wrap",   64'(wa), 64'h1);
    check("ld0_period", 64'(pa), 64'd15);

    // Load wins over en; period survives a load.
    load = 1'b1; en = 1'b1; din = 4'h9;
    tick;
    load = 1'b0; en = 1'b0;
    check("ldn_qa",     64'(qa), 64'h9);
    check("ldn_qb",     64'(qb), 64'h9);
    check("ldn_wrap",   64'(wa), 64'h0);
    check("ldn_lock",   64'(la), 64'h0);
    check("ldn_period", 64'(pa), 64'd15);

    // Reset while advancing.
    en = 1'b1;
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    check("mrst_q",      64'(qa), 64'h0);
    check("mrst_period", 64'(pa), 64'h0);
    check("mrst_pc",     64'(pc), 64'h0);
    check("mrst_wrap",   64'(wa), 64'h0);
    rst_n = 1'b1;
    tick;
    check("mrst_lock", 64'(la), 64'h1);
    en = 1'b0;

    // Default 26-bit polynomial: 26 shifts from 1 lands exactly on POLY.
    din26 = 26'h1; load = 1'b1;
    tick;
    load = 1'b0;
    check("w26_load", 64'(q26), 64'h1);
    en = 1'b1;
    repeat (26) tick;
    en = 1'b0;
    check("w26_q",    64'(q26), 64'h183);
    check("w26_wrap", 64'(w26), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
